// File: rtl/id_ex_skid_reg.sv
// ID->EXE pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Adds bubble insertion, synchronous flush and a saturating count of empty output slots.
module id_ex_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int N_OPER     = 4,
    parameter int REG_AW     = 5,
    parameter int N_REGS     = 3,
    parameter int CTRL_W     = 9,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16,
    localparam int PW        = N_OPER*DATA_W + N_REGS*REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              bubble,
    input  logic              clr_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PW-1:0]     out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              main_valid, skid_valid;
    logic              in_fire, out_fire;
    logic              main_ld_in, main_ld_skid, skid_ld_in;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [PW-1:0]     main_data, skid_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_SKID);

    // in_ready depends only on registered state and bubble, never on out_ready
    assign in_ready  = ~skid_valid & ~bubble;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = main_valid;
    assign out_fire  = out_valid & out_ready;

    // An empty slot must never carry WB/MEM enables downstream
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld_in   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt  = ST_FULL;
                    main_ld_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_ld_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt  = ST_SKID;
                    skid_ld_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt  = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_nxt    = ST_FULL;
                    main_ld_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt    = ST_EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main/skid payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (main_ld_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (main_ld_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (skid_ld_in) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    // Counts cycles whose output slot was empty; flush deliberately leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            bubble_cnt <= '0;
        end else if (!main_valid) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: ordering, backpressure, flush, bubbles, counter saturation.
module tb_id_ex_skid_reg;

    localparam int CTRL_W = 9;
    localparam int PW     = 4*32 + 3*5;
    localparam int BW     = CTRL_W + PW;

    logic              clk, rst_n;
    logic              flush, bubble, clr_cnt, in_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PW-1:0]     in_data;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PW-1:0]     out_data;
    logic [15:0]       bubble_cnt;

    logic              clr2, in_ready2, out_valid2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [PW-1:0]     out_data2;
    logic [3:0]        bubble_cnt2;

    int tests_run = 0;
    int tests_failed = 0;
    int model_cnt = 0;
    logic [BW-1:0] sbq[$];

    id_ex_skid_reg u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bubble(bubble), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .bubble_cnt(bubble_cnt)
    );

    id_ex_skid_reg #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .bubble(1'b0), .clr_cnt(clr2),
        .in_valid(1'b0), .in_ready(in_ready2), .in_ctrl('0), .in_data('0),
        .out_valid(out_valid2), .out_ready(1'b0), .out_ctrl(out_ctrl2),
        .out_data(out_data2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_data(input int i);
        return {32'(i), ~32'(i), 32'(i*7+3), 32'(i) ^ 32'hA5A5_5A5A,
                5'(i), 5'(i+1), 5'(i+2)};
    endfunction

    function automatic logic [CTRL_W-1:0] mk_ctrl(input int i);
        return 9'h100 | 9'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int i);
        in_ctrl = mk_ctrl(i);
        in_data = mk_data(i);
    endtask

    // Scoreboard monitor: pop on out_fire, push on accepted input, track bubble counter
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            model_cnt = 0;
        end else begin
            chk("bubble_cnt", 256'(bubble_cnt), 256'(model_cnt));
            if (!out_valid) chk("ctrl_idle", 256'(out_ctrl), 256'(0));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("sb_extra_beat", 256'(1), 256'(0));
                else chk("beat", 256'({out_ctrl, out_data}), 256'(sbq.pop_front()));
            end
            if (flush) sbq.delete();
            else if (in_valid && in_ready) sbq.push_back({in_ctrl, in_data});
            if (clr_cnt) model_cnt = 0;
            else if (!out_valid && model_cnt != 65535) model_cnt = model_cnt + 1;
        end
    end

    initial begin
        int idx;
        int invalid_slots;
        rst_n = 1'b0; flush = 1'b0; bubble = 1'b0; clr_cnt = 1'b0; clr2 = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; in_ctrl = '0; in_data = '0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_cnt", 256'(bubble_cnt), 256'(0));
        chk("rst_cnt_sat", 256'(bubble_cnt2), 256'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));

        // Streaming 1..100, no gaps
        for (int it = 0; it <= 100; it++) begin
            step();
            in_valid = (it < 100);
            drive_beat(it + 1);
            @(negedge clk);
            if (it >= 1) chk("stream_gap", 256'(out_valid), 256'(1));
        end
        step(); in_valid = 1'b0;
        step();

        // Backpressure: A held, B skids, C refused
        step(); out_ready = 1'b0; in_valid = 1'b1; drive_beat(201);
        step(); drive_beat(202);
        step(); drive_beat(203);
        @(negedge clk);
        chk("skid_in_ready", 256'(in_ready), 256'(0));
        chk("skid_out_data", 256'(out_data), 256'(mk_data(201)));
        step();
        @(negedge clk);
        chk("stall_out_data", 256'(out_data), 256'(mk_data(201)));
        chk("stall_out_ctrl", 256'(out_ctrl), 256'(mk_ctrl(201)));
        step(); in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("bp_drained", 256'(sbq.size()), 256'(0));

        // Flush while SKID holds a beat and C is presented
        step(); out_ready = 1'b0; in_valid = 1'b1; drive_beat(301);
        step(); drive_beat(302);
        step(); drive_beat(303); flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        chk("flush_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("flush_in_ready", 256'(in_ready), 256'(1));
        step(); out_ready = 1'b1;
        repeat (3) step();

        // Flush in FULL drops a beat firing in the same cycle
        step(); out_ready = 1'b0; in_valid = 1'b1; drive_beat(311);
        step(); drive_beat(312); flush = 1'b1;
        step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", 256'(out_valid), 256'(0));
        step(); out_ready = 1'b1;
        repeat (3) step();

        // Three bubble cycles inside a steady stream
        idx = 500;
        invalid_slots = 0;
        for (int it = 0; it <= 13; it++) begin
            step();
            in_valid = (it < 13);
            bubble = (it >= 4 && it <= 6);
            drive_beat(idx);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (it >= 1 && !out_valid) invalid_slots++;
        end
        chk("bubble_slots", 256'(invalid_slots), 256'(3));
        step(); in_valid = 1'b0; bubble = 1'b0;
        step();

        // Counter clear on the main instance
        step(); clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_cnt", 256'(bubble_cnt), 256'(0));

        // Async reset mid-stream with SKID occupied
        step(); out_ready = 1'b0; in_valid = 1'b1; drive_beat(401);
        step(); drive_beat(402);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_skid", 256'(in_ready), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_out_ctrl", 256'(out_ctrl), 256'(0));
        chk("arst_in_ready", 256'(in_ready), 256'(1));
        chk("arst_cnt", 256'(bubble_cnt), 256'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) step();

        // Saturation with CNT_W=4
        step(); clr2 = 1'b1;
        step(); clr2 = 1'b0;
        @(negedge clk);
        chk("sat_clr", 256'(bubble_cnt2), 256'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_count3", 256'(bubble_cnt2), 256'(3));
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_max", 256'(bubble_cnt2), 256'(15));
        step(); clr2 = 1'b1;
        step(); clr2 = 1'b0;
        @(negedge clk);
        chk("sat_clr_after", 256'(bubble_cnt2), 256'(0));

        step();
        chk("sb_empty", 256'(sbq.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
